// File: rtl/cnn_pkg.sv
// Shared types and per-layer configuration tables for the CNN layer sequencer.
package cnn_pkg;

    localparam int unsigned N_LAYER_DEF = 5;
    localparam int unsigned N_MEM_DEF   = 12;

    typedef enum logic [1:0] {
        CONV = 2'd0,
        POOL = 2'd1,
        FC   = 2'd2
    } layer_type_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    typedef struct packed {
        layer_type_e            ltype;
        logic [1:0]             msel;
        logic [N_MEM_DEF-1:0]   mask;
    } layer_cfg_t;

    // conv1, pool1, conv2, pool2, fc
    localparam layer_type_e LAYER_TYPE [N_LAYER_DEF] = '{CONV, POOL, CONV, POOL, FC};
    localparam logic [1:0]  LAYER_MSEL [N_LAYER_DEF] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    localparam logic [N_MEM_DEF-1:0] LAYER_MASK [N_LAYER_DEF] = '{
        12'h007,    // conv1: image, weights, feature-out
        12'h018,    // pool1: feature-in, pool-out
        12'h0E0,    // conv2: feature-in, weights, feature-out
        12'h300,    // pool2: feature-in, pool-out
        12'hC00     // fc: vector-in, weights
    };

    // Table lookup; an index beyond the table yields a CONV layer with an empty mask.
    function automatic layer_cfg_t layer_cfg(input logic [7:0] idx);
        layer_cfg_t cfg;
        cfg = '{ltype: CONV, msel: 2'd0, mask: '0};
        for (int unsigned i = 0; i < N_LAYER_DEF; i++) begin
            if (idx == 8'(i)) begin
                cfg.ltype = LAYER_TYPE[i];
                cfg.msel  = LAYER_MSEL[i];
                cfg.mask  = LAYER_MASK[i];
            end
        end
        return cfg;
    endfunction

endpackage

// File: rtl/cnn_layer_seq_if.sv
// Host/datapath bus of the CNN layer sequencer.
interface cnn_layer_seq_if
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_MEMS = N_MEM_DEF
);
    logic                   start;
    logic                   abort;
    logic                   img_load_done;
    logic [NUM_MEMS-1:0]    mem_done;
    logic                   img_load;
    logic [NUM_MEMS-1:0]    mem_reset;
    logic                   MAC_enable;
    logic                   rMAC;
    logic                   pooling_layer;
    logic [1:0]             MAC_layer;
    logic [7:0]             layer_idx;
    logic [7:0]             return_ctrl;
    logic                   busy;
    logic                   done;
    logic                   error;

    modport master (
        output start, abort, img_load_done, mem_done,
        input  img_load, mem_reset, MAC_enable, rMAC, pooling_layer,
               MAC_layer, layer_idx, return_ctrl, busy, done, error
    );

    modport slave (
        input  start, abort, img_load_done, mem_done,
        output img_load, mem_reset, MAC_enable, rMAC, pooling_layer,
               MAC_layer, layer_idx, return_ctrl, busy, done, error
    );
endinterface

// File: rtl/cnn_wdog.sv
// Clearable saturating watchdog counter; terminal flag marks the cycle whose increment reaches all-ones.
module cnn_wdog #(
    parameter int unsigned WDOG_W = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term_c
);
    localparam logic [WDOG_W-1:0] MAX = '1;

    logic [WDOG_W-1:0] r_count;

    // Count with saturation; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + WDOG_W'(1);
        end
    end

    assign o_term_c = i_inc && (r_count >= (MAX - WDOG_W'(1)));

endmodule

// File: rtl/cnn_layer_seq.sv
// Sequences image load and the compute layers of a small CNN, driving memory-port resets and MAC controls.
module cnn_layer_seq
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = N_LAYER_DEF,
    parameter int unsigned NUM_MEMS   = N_MEM_DEF,
    parameter int unsigned WDOG_W     = 20
) (
    input logic             clk,
    input logic             reset_n,
    cnn_layer_seq_if.slave  bus
);
    state_e                 r_state, w_state_nxt;
    logic [7:0]             r_layer_idx, w_layer_idx_nxt;
    logic [7:0]             r_return_ctrl, w_return_ctrl_nxt;
    layer_cfg_t             w_cur_cfg, w_nxt_cfg;
    logic [NUM_MEMS-1:0]    w_cur_mask, w_nxt_mask;
    logic                   w_layer_done;
    logic                   w_wdog_clr, w_wdog_inc, w_wdog_term;

    logic                   r_img_load, w_img_load_nxt;
    logic [NUM_MEMS-1:0]    r_mem_reset, w_mem_reset_nxt;
    logic                   r_mac_enable, w_mac_enable_nxt;
    logic                   r_rmac, w_rmac_nxt;
    logic                   r_pooling, w_pooling_nxt;
    logic [1:0]             r_mac_layer, w_mac_layer_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_error, w_error_nxt;

    assign w_cur_cfg    = layer_cfg(r_layer_idx);
    assign w_nxt_cfg    = layer_cfg(w_layer_idx_nxt);
    assign w_cur_mask   = NUM_MEMS'(w_cur_cfg.mask);
    assign w_nxt_mask   = NUM_MEMS'(w_nxt_cfg.mask);
    assign w_layer_done = ((bus.mem_done & w_cur_mask) == w_cur_mask);

    assign w_wdog_inc = (r_state == LOAD) || (r_state == RUN);
    assign w_wdog_clr = ((w_state_nxt == LOAD) && (r_state != LOAD)) || (w_state_nxt == ARM);

    cnn_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_wdog_clr),
        .i_inc    (w_wdog_inc),
        .o_term_c (w_wdog_term)
    );

    // Next state, layer index and progress code; abort overrides everything.
    always_comb begin
        w_state_nxt       = r_state;
        w_layer_idx_nxt   = r_layer_idx;
        w_return_ctrl_nxt = r_return_ctrl;
        if (bus.abort) begin
            w_state_nxt     = IDLE;
            w_layer_idx_nxt = 8'd0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        w_state_nxt       = LOAD;
                        w_layer_idx_nxt   = 8'd0;
                        w_return_ctrl_nxt = 8'd0;
                    end
                end
                LOAD: begin
                    if (bus.img_load_done) begin
                        w_state_nxt       = ARM;
                        w_layer_idx_nxt   = 8'd0;
                        w_return_ctrl_nxt = 8'd1;
                    end else if (w_wdog_term) begin
                        w_state_nxt = ERR;
                    end
                end
                ARM: begin
                    w_state_nxt = RUN;
                end
                RUN: begin
                    if (w_layer_done) begin
                        w_state_nxt       = DRAIN;
                        w_return_ctrl_nxt = r_layer_idx + 8'd2;
                    end else if (w_wdog_term) begin
                        w_state_nxt     = ERR;
                        w_layer_idx_nxt = 8'd0;
                    end
                end
                DRAIN: begin
                    if (r_layer_idx == 8'(NUM_LAYERS - 1)) begin
                        w_state_nxt     = DONE;
                        w_layer_idx_nxt = 8'd0;
                    end else begin
                        w_state_nxt     = ARM;
                        w_layer_idx_nxt = r_layer_idx + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_layer_idx_nxt = 8'd0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state so the registered outputs line up with it.
    always_comb begin
        w_img_load_nxt   = 1'b0;
        w_mem_reset_nxt  = '1;
        w_mac_enable_nxt = 1'b0;
        w_rmac_nxt       = 1'b1;
        w_pooling_nxt    = 1'b0;
        w_mac_layer_nxt  = 2'd0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_error_nxt      = 1'b0;
        case (w_state_nxt)
            LOAD: begin
                w_img_load_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            ARM, RUN: begin
                w_busy_nxt      = 1'b1;
                w_mem_reset_nxt = ~w_nxt_mask;
                w_rmac_nxt      = 1'b0;
                case (w_nxt_cfg.ltype)
                    CONV: begin
                        w_mac_enable_nxt = 1'b1;
                        w_mac_layer_nxt  = w_nxt_cfg.msel;
                    end
                    POOL: begin
                        w_pooling_nxt = 1'b1;
                        w_rmac_nxt    = (w_state_nxt == RUN);
                    end
                    FC: begin
                        w_mac_enable_nxt = 1'b1;
                        w_mac_layer_nxt  = 2'b10;
                    end
                    default: begin
                        w_mac_enable_nxt = 1'b0;
                    end
                endcase
            end
            DRAIN:   w_busy_nxt  = 1'b1;
            DONE:    w_done_nxt  = 1'b1;
            ERR:     w_error_nxt = 1'b1;
            default: w_busy_nxt  = 1'b0;
        endcase
    end

    // State, index and progress-code registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_layer_idx   <= 8'd0;
            r_return_ctrl <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_layer_idx   <= w_layer_idx_nxt;
            r_return_ctrl <= w_return_ctrl_nxt;
        end
    end

    // Registered datapath controls and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_img_load   <= 1'b0;
            r_mem_reset  <= '1;
            r_mac_enable <= 1'b0;
            r_rmac       <= 1'b1;
            r_pooling    <= 1'b0;
            r_mac_layer  <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_img_load   <= w_img_load_nxt;
            r_mem_reset  <= w_mem_reset_nxt;
            r_mac_enable <= w_mac_enable_nxt;
            r_rmac       <= w_rmac_nxt;
            r_pooling    <= w_pooling_nxt;
            r_mac_layer  <= w_mac_layer_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
        end
    end

    assign bus.img_load      = r_img_load;
    assign bus.mem_reset     = r_mem_reset;
    assign bus.MAC_enable    = r_mac_enable;
    assign bus.rMAC          = r_rmac;
    assign bus.pooling_layer = r_pooling;
    assign bus.MAC_layer     = r_mac_layer;
    assign bus.layer_idx     = r_layer_idx;
    assign bus.return_ctrl   = r_return_ctrl;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;

endmodule
